// File: rtl/key_pkg.sv
// Shared definitions for the key event controller: event codes and the
// per-key gesture state encoding.
package key_pkg;

    typedef logic [1:0] evt_code_t;

    localparam evt_code_t EVT_SHORT  = 2'd0;
    localparam evt_code_t EVT_DOUBLE = 2'd1;
    localparam evt_code_t EVT_LONG   = 2'd2;
    localparam evt_code_t EVT_REPEAT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        WAIT_DC,
        PRESS2,
        HOLD
    } key_state_t;

endpackage

// File: rtl/key_gesture_fsm.sv
// One key's gesture classifier: a millisecond-timed FSM plus a single-entry
// pending slot that the top-level arbiter drains.
module key_gesture_fsm
    import key_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int DCLK_MS   = 250,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_lvl,
    input  logic       tick,
    input  logic       grant,
    output logic       pend,
    output logic [1:0] pend_code,
    output logic       ovf_set
);

    localparam logic [15:0] LONG_END = 16'(LONG_MS - 1);
    localparam logic [15:0] DCLK_END = 16'(DCLK_MS - 1);
    localparam logic [15:0] REP_END  = 16'(REPEAT_MS - 1);

    key_state_t  state;
    logic [15:0] cnt;
    logic        emit;
    evt_code_t   emit_code;

    // A release always beats a timeout, so every timeout requires the level
    // that keeps the FSM in its current state.
    always_comb begin
        emit      = 1'b0;
        emit_code = EVT_SHORT;
        case (state)
            PRESS: if (key_lvl && tick && cnt == LONG_END) begin
                emit      = 1'b1;
                emit_code = EVT_LONG;
            end
            WAIT_DC: if (!key_lvl && tick && cnt == DCLK_END) begin
                emit      = 1'b1;
                emit_code = EVT_SHORT;
            end
            PRESS2: if (!key_lvl) begin
                emit      = 1'b1;
                emit_code = EVT_DOUBLE;
            end
            HOLD: if (key_lvl && tick && cnt == REP_END) begin
                emit      = 1'b1;
                emit_code = EVT_REPEAT;
            end
            default: ;
        endcase
    end

    // A grant on the same edge consumes the old code, so that is not a drop.
    assign ovf_set = emit && pend && !grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_code <= EVT_SHORT;
        end else begin
            if (emit) begin
                pend      <= 1'b1;
                pend_code <= emit_code;
            end else if (grant) begin
                pend <= 1'b0;
            end

            case (state)
                IDLE: if (key_lvl) begin
                    state <= PRESS;
                    cnt   <= '0;
                end
                PRESS: if (!key_lvl) begin
                    state <= WAIT_DC;
                    cnt   <= '0;
                end else if (tick) begin
                    if (cnt == LONG_END) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_DC: if (key_lvl) begin
                    state <= PRESS2;
                end else if (tick) begin
                    if (cnt == DCLK_END) state <= IDLE;
                    else                 cnt   <= cnt + 16'd1;
                end
                PRESS2: if (!key_lvl) state <= IDLE;
                HOLD: if (!key_lvl) begin
                    state <= IDLE;
                end else if (tick) begin
                    if (cnt == REP_END) cnt <= '0;
                    else                cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: shared ms prescaler, per-key gesture FSMs, round-robin
// arbiter into an event FIFO. Output handshake: the head entry transfers on
// an edge where evt_valid and evt_ready are both high; it is held otherwise.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int KEY_NUM    = 4,
    parameter int TICK_DIV   = 50_000,
    parameter int LONG_MS    = 1000,
    parameter int DCLK_MS    = 250,
    parameter int REPEAT_MS  = 200,
    parameter int FIFO_DEPTH = 4,
    localparam int KW = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_lvl,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [KW-1:0]      evt_key,
    output logic [1:0]         evt_code,
    output logic               evt_ovf,
    input  logic               ovf_clr
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    logic [KEY_NUM-1:0] pend_vec;
    logic [KEY_NUM-1:0] grant_vec;
    logic [KEY_NUM-1:0] ovf_vec;
    logic [1:0]         pend_code [KEY_NUM];

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_gesture_fsm #(
            .LONG_MS   (LONG_MS),
            .DCLK_MS   (DCLK_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .key_lvl   (key_lvl[k]),
            .tick      (tick),
            .grant     (grant_vec[k]),
            .pend      (pend_vec[k]),
            .pend_code (pend_code[k]),
            .ovf_set   (ovf_vec[k])
        );
    end

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [KW-1:0] mem_key  [FIFO_DEPTH];
    logic [1:0]    mem_code [FIFO_DEPTH];
    logic          full, pop;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign evt_valid = (wr_ptr != rd_ptr);
    assign evt_key   = mem_key[rd_ptr[AW-1:0]];
    assign evt_code  = mem_code[rd_ptr[AW-1:0]];
    assign pop       = evt_valid && evt_ready;

    // Round-robin search starts one past the last granted key; fullness is
    // judged before any same-cycle pop.
    logic [KW-1:0] rr_ptr, grant_idx, idx;
    logic [KW:0]   idx_w;
    logic          grant_any;

    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx_w     = '0;
        idx       = '0;
        for (int i = 1; i <= KEY_NUM; i++) begin
            idx_w = {1'b0, rr_ptr} + (KW+1)'(i);
            if (idx_w >= (KW+1)'(KEY_NUM)) idx_w = idx_w - (KW+1)'(KEY_NUM);
            idx = idx_w[KW-1:0];
            if (!grant_any && !full && pend_vec[idx]) begin
                grant_any      = 1'b1;
                grant_idx      = idx;
                grant_vec[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= KW'(KEY_NUM - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_key[i]  <= '0;
                mem_code[i] <= EVT_SHORT;
            end
        end else begin
            if (grant_any) begin
                rr_ptr                   <= grant_idx;
                mem_key[wr_ptr[AW-1:0]]  <= grant_idx;
                mem_code[wr_ptr[AW-1:0]] <= pend_code[grant_idx];
                wr_ptr                   <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        evt_ovf <= 1'b0;
        else if (|ovf_vec) evt_ovf <= 1'b1;
        else if (ovf_clr)  evt_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed gestures plus random key traffic, scored
// cycle by cycle against a timestamp-based gesture/queue model.
module tb_key_event_ctrl;
    import key_pkg::*;

    localparam int KEY_NUM    = 4;
    localparam int TICK_DIV   = 10;
    localparam int LONG_MS    = 20;
    localparam int DCLK_MS    = 5;
    localparam int REPEAT_MS  = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int KW         = 2;
    localparam int W          = KW + 2;

    // clock / reset
    logic               clk = 1'b0;
    logic               rst_n;
    logic [KEY_NUM-1:0] key_lvl;
    logic               evt_valid, evt_ready, evt_ovf, ovf_clr;
    logic [KW-1:0]      evt_key;
    logic [1:0]         evt_code;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .KEY_NUM(KEY_NUM), .TICK_DIV(TICK_DIV), .LONG_MS(LONG_MS),
        .DCLK_MS(DCLK_MS), .REPEAT_MS(REPEAT_MS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_key(evt_key), .evt_code(evt_code),
        .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a gesture is judged by how many ms ticks have elapsed
    // since the edge that started its current phase.
    localparam int PH_REL = 0, PH_DOWN = 1, PH_GAP = 2, PH_DOWN2 = 3, PH_HELD = 4;
    int            ph      [KEY_NUM];
    int            mark    [KEY_NUM];
    bit            pend_m  [KEY_NUM];
    logic [1:0]    pcode_m [KEY_NUM];
    int            last_m, div_m, tk_m;
    bit            ovf_m;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];
    logic [W-1:0]  want_q[$];
    logic [W-1:0]  head_m;

    task automatic model_reset();
        for (int k = 0; k < KEY_NUM; k++) begin
            ph[k] = PH_REL; mark[k] = 0; pend_m[k] = 0; pcode_m[k] = EVT_SHORT;
        end
        last_m = KEY_NUM - 1; div_m = 0; tk_m = 0; ovf_m = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit            t, do_pop, ovf_set;
        int            tk_new, g, cand;
        bit            emit  [KEY_NUM];
        logic [1:0]    ecode [KEY_NUM];
        logic [KW-1:0] gk;
        t      = (div_m == TICK_DIV - 1);
        div_m  = t ? 0 : div_m + 1;
        tk_new = tk_m + (t ? 1 : 0);
        for (int k = 0; k < KEY_NUM; k++) begin
            emit[k] = 0; ecode[k] = EVT_SHORT;
            case (ph[k])
                PH_REL: if (key_lvl[k]) begin ph[k] = PH_DOWN; mark[k] = tk_new; end
                PH_DOWN:
                    if (!key_lvl[k]) begin ph[k] = PH_GAP; mark[k] = tk_new; end
                    else if (t && tk_new - mark[k] == LONG_MS) begin
                        emit[k] = 1; ecode[k] = EVT_LONG; ph[k] = PH_HELD; mark[k] = tk_new;
                    end
                PH_GAP:
                    if (key_lvl[k]) ph[k] = PH_DOWN2;
                    else if (t && tk_new - mark[k] == DCLK_MS) begin
                        emit[k] = 1; ecode[k] = EVT_SHORT; ph[k] = PH_REL;
                    end
                PH_DOWN2: if (!key_lvl[k]) begin emit[k] = 1; ecode[k] = EVT_DOUBLE; ph[k] = PH_REL; end
                default:
                    if (!key_lvl[k]) ph[k] = PH_REL;
                    else if (t && tk_new - mark[k] == REPEAT_MS) begin
                        emit[k] = 1; ecode[k] = EVT_REPEAT; mark[k] = tk_new;
                    end
            endcase
        end
        tk_m   = tk_new;
        do_pop = (exp_q.size() > 0) && evt_ready;
        g      = -1;
        if (exp_q.size() < FIFO_DEPTH)
            for (int i = 1; i <= KEY_NUM; i++) begin
                cand = (last_m + i) % KEY_NUM;
                if (g < 0 && pend_m[cand]) g = cand;
            end
        if (do_pop) void'(exp_q.pop_front());
        if (g >= 0) begin
            gk = KW'(g);
            exp_q.push_back({gk, pcode_m[g]});
            pend_m[g] = 0;
            last_m    = g;
        end
        ovf_set = 0;
        for (int k = 0; k < KEY_NUM; k++)
            if (emit[k]) begin
                if (pend_m[k]) ovf_set = 1;
                pend_m[k] = 1; pcode_m[k] = ecode[k];
            end
        if (ovf_set)      ovf_m = 1;
        else if (ovf_clr) ovf_m = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // scoreboard: every cycle the DUT must show the model's FIFO head and flag
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(evt_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head_m = exp_q[0];
                check("head_key", 32'(evt_key), 32'(head_m[W-1:2]));
                check("head_code", 32'(evt_code), 32'(head_m[1:0]));
            end
            check("ovf", 32'(evt_ovf), 32'(ovf_m));
            if (evt_valid && evt_ready) got_q.push_back({evt_key, evt_code});
        end
    end

    // driver tasks: inputs change 2 time units after a rising edge
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic gesture(input int k, input int hold, input int gap);
        key_lvl[k] = 1'b1;
        cycles(hold);
        key_lvl[k] = 1'b0;
        cycles(gap);
    endtask

    task automatic want(input int k, input logic [1:0] code);
        logic [KW-1:0] kk;
        kk = KW'(k);
        want_q.push_back({kk, code});
    endtask

    task automatic check_got(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(want_q.size()));
        for (int i = 0; i < got_q.size() && i < want_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(want_q[i]));
        got_q.delete();
        want_q.delete();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !evt_valid; i++) cycles(1);
        check("wait_valid", 32'(evt_valid), 32'd1);
    endtask

    int cd [KEY_NUM];

    initial begin
        rst_n = 1'b0; key_lvl = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        cycles(3);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_key", 32'(evt_key), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_ovf", 32'(evt_ovf), 0);
        rst_n = 1'b1;
        cycles(5);

        // single short press
        got_q.delete();
        gesture(1, 50, 100);
        want(1, EVT_SHORT);
        check_got("short");

        // double click
        gesture(0, 30, 20);
        gesture(0, 30, 30);
        want(0, EVT_DOUBLE);
        check_got("double");

        // long hold with two repeats, silent release
        gesture(2, 300, 60);
        want(2, EVT_LONG); want(2, EVT_REPEAT); want(2, EVT_REPEAT);
        check_got("long");

        // reset during HOLD with a queued event
        evt_ready = 1'b0;
        key_lvl[3] = 1'b1;
        cycles(250);
        check("hold_valid", 32'(evt_valid), 1);
        check("hold_key", 32'(evt_key), 3);
        check("hold_code", 32'(evt_code), 32'(EVT_LONG));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 0);
        check("mid_rst_key", 32'(evt_key), 0);
        check("mid_rst_code", 32'(evt_code), 0);
        check("mid_rst_ovf", 32'(evt_ovf), 0);
        cycles(2);
        got_q.delete();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        cycles(225);
        key_lvl[3] = 1'b0;
        cycles(30);
        want(3, EVT_LONG);
        check_got("post_rst");

        // FIFO fill, pend overwrite, drain order
        evt_ready = 1'b0;
        key_lvl = '1;
        cycles(30);
        key_lvl = '0;
        cycles(80);
        gesture(0, 30, 80);
        check("ovf_pend_only", 32'(evt_ovf), 0);
        gesture(0, 30, 80);
        check("ovf_overwrite", 32'(evt_ovf), 1);
        got_q.delete();
        evt_ready = 1'b1;
        cycles(20);
        for (int k = 0; k < KEY_NUM; k++) want(k, EVT_SHORT);
        want(0, EVT_SHORT);
        check_got("fill");
        check("ovf_sticky", 32'(evt_ovf), 1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(evt_ovf), 0);

        // head stability under backpressure, then push+pop on one edge
        evt_ready = 1'b0;
        gesture(1, 30, 0);
        wait_valid(100);
        repeat (100) begin
            cycles(1);
            check("stall_valid", 32'(evt_valid), 1);
            check("stall_key", 32'(evt_key), 1);
            check("stall_code", 32'(evt_code), 32'(EVT_SHORT));
        end
        key_lvl[2] = 1'b1; key_lvl[3] = 1'b1;
        cycles(30);
        key_lvl[2] = 1'b0; key_lvl[3] = 1'b0;
        for (int i = 0; i < 200 && !pend_m[2]; i++) cycles(1);
        check("pend2_seen", 32'(pend_m[2]), 1);
        got_q.delete();
        evt_ready = 1'b1;
        cycles(20);
        want(1, EVT_SHORT); want(2, EVT_SHORT); want(3, EVT_SHORT);
        check_got("pushpop");

        // random traffic
        for (int k = 0; k < KEY_NUM; k++) cd[k] = $urandom_range(1, 50);
        repeat (15000) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                cd[k]--;
                if (cd[k] == 0) begin
                    key_lvl[k] = ~key_lvl[k];
                    cd[k] = key_lvl[k] ? $urandom_range(3, 320) : $urandom_range(3, 90);
                end
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 49) == 0);
            cycles(1);
        end
        key_lvl = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
        cycles(200);
        check("drained", 32'(evt_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog timeout t=%0t", $time);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sits downstream of the key debouncer; consumes debounced, synchronous, active-high key levels.
- Runs one timing state machine per key and classifies each gesture as SHORT, DOUBLE, LONG or REPEAT.
- Arbitrates round-robin between keys with pending events into a small FIFO.
- Presents the FIFO to a single consumer (menu/parameter logic) over a valid/ready handshake.

Parameters:
- KEY_NUM, 4: number of keys (1..8).
- TICK_DIV, 50_000: clk cycles per 1 ms tick (50 MHz).
- LONG_MS, 1000: hold time, in ticks, that produces LONG.
- DCLK_MS, 250: release window, in ticks, in which a second press forms DOUBLE.
- REPEAT_MS, 200: REPEAT period while held after LONG.
- FIFO_DEPTH, 4: event FIFO depth; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_lvl  in  KEY_NUM  debounced key level, 1 = pressed, synchronous to clk.
- evt_valid  out  1  head of FIFO valid.
- evt_ready  in  1  consumer accepts the head when high together with evt_valid.
- evt_key  out  $clog2(KEY_NUM) (minimum 1)  key index of the head event.
- evt_code  out  2  event code: 0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT.
- evt_ovf  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears evt_ovf.

Behaviour:
- Reset: all per-key FSMs go to IDLE; tick counters, pending flags and FIFO pointers clear; evt_valid=0, evt_key=0, evt_code=0, evt_ovf=0. Asserting reset mid-gesture discards the gesture; a key still held at release of reset enters PRESS on the first clock.
- Tick prescaler:
  - Counts 0..TICK_DIV-1.
  - tick is high for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
  - Free-running; shared by all keys.
- Per-key FSM, with a 16-bit ms counter cnt that increments on tick only:
  - IDLE: key_lvl=1 -> PRESS, cnt=0.
  - PRESS: release -> WAIT_DC, cnt=0. Otherwise, if tick and cnt==LONG_MS-1 -> emit LONG, go to HOLD, cnt=0.
  - WAIT_DC: press -> PRESS2. Otherwise, if tick and cnt==DCLK_MS-1 -> emit SHORT, go to IDLE.
  - PRESS2: release -> emit DOUBLE, go to IDLE. There is no LONG from PRESS2, whatever the hold duration.
  - HOLD: release -> IDLE, no event. Otherwise, if tick and cnt==REPEAT_MS-1 -> emit REPEAT, cnt=0.
  - A release and a timeout on the same cycle: the release wins.
- Pending slot (one per key):
  - An emit sets pend and pend_code on the next edge.
  - An emit while pend is already set overwrites pend_code and sets evt_ovf.
  - An emit on the same cycle as that key's grant: the grant takes the old code, and pend stays set with the new code.
- Arbiter:
  - When the FIFO is not full and any pend is set, it grants one key per cycle.
  - Search order is round-robin, starting at the key after the last granted key. The pointer resets to the last key index, so key 0 wins first.
  - A grant clears pend and pushes {key, code} on the same edge.
  - No grant occurs when the FIFO is full, even if a pop happens that cycle.
- FIFO and handshake:
  - evt_valid = not empty. evt_key and evt_code are the head entry, stable while evt_valid=1 and evt_ready=0.
  - A pop occurs on an edge where evt_valid and evt_ready are both high.
  - Push and pop on the same cycle are both allowed.
  - Latency: pend set at edge E -> with the FIFO empty, evt_valid=1 after edge E+1.
- evt_ovf:
  - Also set when any pend is overwritten while the FIFO is full; the FIFO itself never overflows.
  - ovf_clr clears evt_ovf. If a set and ovf_clr occur on the same cycle, the set wins.

Decomposition:
- Shared package key_pkg holds:
  - the event-code constants EVT_SHORT=0, EVT_DOUBLE=1, EVT_LONG=2, EVT_REPEAT=3;
  - the FSM state typedef (IDLE, PRESS, WAIT_DC, PRESS2, HOLD);
  - the 2-bit evt_code_t typedef.
- Sub-module key_gesture_fsm (one key: FSM, cnt, pend, pend_code) is generated KEY_NUM times.
- The prescaler, arbiter and FIFO stay in the top level.

Test Plan (TICK_DIV=10, LONG_MS=20, DCLK_MS=5, REPEAT_MS=4, KEY_NUM=4, evt_ready=1 unless stated):
- Key 1 pressed for 50 cycles, then released -> one event {key=1, SHORT}, evt_valid about 50 cycles after release; no other event.
- Key 0 pressed 30 cycles, released 20, pressed 30, released -> exactly one {0, DOUBLE}, one cycle after pend sets following the second release.
- Key 2 held for 300 cycles -> {2, LONG} at about 200 cycles, then {2, REPEAT} every 40 cycles (two REPEATs); nothing on release.
- Keys 0-3 emit SHORT on the same cycle, evt_ready=0 -> FIFO fills in order 0,1,2,3. Then a fifth gesture on key 0, then its second overwrite -> evt_ovf=1. Raise evt_ready -> pops 0,1,2,3, then key 0's surviving event. ovf_clr -> evt_ovf=0.
- evt_ready=0 with head {1, SHORT} -> evt_valid, evt_key and evt_code hold for 100 cycles. Push and pop on the same cycle -> count unchanged, order preserved.
- Reset asserted mid-HOLD of key 3 with the FIFO non-empty -> outputs clear on the same edge. Key still held after reset -> LONG again after about 200 cycles.
